// File: rtl/udp_i2c_slave.sv
// I2C slave: 7-bit address match, byte write to rx_data, byte read from tx_data.
// Latency: bus events act 2 + FILT_LEN clks after the raw pad edge (synchronizer + glitch filter).
// Backpressure: none; tx_data must be valid at the SCL fall that follows a tx_req pulse.
module udp_i2c_slave #(
  parameter int FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [6:0] slv_addr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       start_det,
  output logic       stop_det,
  output logic       slv_busy,
  output logic       slv_rw
);

  localparam logic [2:0] FILT_MAX = 3'(FILT_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  // Two-flop synchronizers; preset to the idle bus level (high)
  logic [1:0] scl_sync, sda_sync;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
    end
  end

  // Glitch filter: a new level is accepted after FILT_LEN consecutive differing samples.
  // The accepted ("next") level is used directly so bus events are seen on the update edge.
  logic       scl_f, sda_f, scl_f_nxt, sda_f_nxt;
  logic [2:0] scl_cnt, sda_cnt, scl_cnt_nxt, sda_cnt_nxt;
  always_comb begin
    scl_f_nxt   = scl_f;
    sda_f_nxt   = sda_f;
    scl_cnt_nxt = 3'd0;
    sda_cnt_nxt = 3'd0;
    if (scl_sync[1] != scl_f) begin
      if (scl_cnt == FILT_MAX) scl_f_nxt = scl_sync[1];
      else                     scl_cnt_nxt = scl_cnt + 3'd1;
    end
    if (sda_sync[1] != sda_f) begin
      if (sda_cnt == FILT_MAX) sda_f_nxt = sda_sync[1];
      else                     sda_cnt_nxt = sda_cnt + 3'd1;
    end
  end

  // Filtered level and filter run-length registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= 3'd0;
      sda_cnt <= 3'd0;
    end else begin
      scl_f   <= scl_f_nxt;
      sda_f   <= sda_f_nxt;
      scl_cnt <= scl_cnt_nxt;
      sda_cnt <= sda_cnt_nxt;
    end
  end

  logic scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_rise = ~scl_f & scl_f_nxt;
  assign scl_fall = scl_f & ~scl_f_nxt;
  assign start_ev = scl_f & scl_f_nxt & sda_f & ~sda_f_nxt;
  assign stop_ev  = scl_f & scl_f_nxt & ~sda_f & sda_f_nxt;

  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [6:0] shreg, shreg_nxt;
  logic [6:0] tx_shreg, tx_shreg_nxt;
  logic       ack_on, ack_on_nxt;
  logic       sda_oe_nxt, slv_busy_nxt, slv_rw_nxt;
  logic [7:0] rx_data_nxt, rx_byte;
  logic       rx_valid_nxt, tx_req_nxt, start_det_nxt, stop_det_nxt;

  // Protocol state, shift registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 7'd0;
      tx_shreg  <= 7'd0;
      ack_on    <= 1'b0;
      sda_oe    <= 1'b0;
      slv_busy  <= 1'b0;
      slv_rw    <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      tx_shreg  <= tx_shreg_nxt;
      ack_on    <= ack_on_nxt;
      sda_oe    <= sda_oe_nxt;
      slv_busy  <= slv_busy_nxt;
      slv_rw    <= slv_rw_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= rx_valid_nxt;
      tx_req    <= tx_req_nxt;
      start_det <= start_det_nxt;
      stop_det  <= stop_det_nxt;
    end
  end

  // Next-state and output logic; START/STOP override every state.
  // ack_on marks the second half of an ACK slot (driven on one fall, released on the next).
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    tx_shreg_nxt  = tx_shreg;
    ack_on_nxt    = ack_on;
    sda_oe_nxt    = sda_oe;
    slv_busy_nxt  = slv_busy;
    slv_rw_nxt    = slv_rw;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = 1'b0;
    tx_req_nxt    = 1'b0;
    start_det_nxt = start_ev;
    stop_det_nxt  = stop_ev;
    rx_byte       = {shreg, sda_f};

    if (start_ev) begin
      state_nxt    = ADDR;
      bit_cnt_nxt  = 3'd0;
      sda_oe_nxt   = 1'b0;
      slv_busy_nxt = 1'b0;
      ack_on_nxt   = 1'b0;
    end else if (stop_ev) begin
      state_nxt    = IDLE;
      sda_oe_nxt   = 1'b0;
      slv_busy_nxt = 1'b0;
      ack_on_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shreg_nxt   = rx_byte[6:0];
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              // Equality also covers general call: address 0 matches only when slv_addr is 0
              if (rx_byte[7:1] == slv_addr) begin
                slv_rw_nxt   = rx_byte[0];
                slv_busy_nxt = 1'b1;
                tx_req_nxt   = rx_byte[0];
                ack_on_nxt   = 1'b0;
                state_nxt    = ADDR_ACK;
              end else begin
                sda_oe_nxt = 1'b0;
                state_nxt  = WAIT_STOP;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_on) begin
              sda_oe_nxt = 1'b1;
              ack_on_nxt = 1'b1;
            end else begin
              ack_on_nxt  = 1'b0;
              bit_cnt_nxt = 3'd0;
              if (slv_rw) begin
                tx_shreg_nxt = tx_data[6:0];
                sda_oe_nxt   = ~tx_data[7];
                state_nxt    = RD_DATA;
              end else begin
                sda_oe_nxt = 1'b0;
                state_nxt  = WR_DATA;
              end
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shreg_nxt   = rx_byte[6:0];
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_nxt  = rx_byte;
              rx_valid_nxt = 1'b1;
              ack_on_nxt   = 1'b0;
              state_nxt    = WR_ACK;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (!ack_on) begin
              sda_oe_nxt = 1'b1;
              ack_on_nxt = 1'b1;
            end else begin
              sda_oe_nxt  = 1'b0;
              ack_on_nxt  = 1'b0;
              bit_cnt_nxt = 3'd0;
              state_nxt   = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          // Bit 7 was driven on entry; falls 1..7 drive bits 6..0, fall 8 frees SDA for the master
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = 3'd0;
              ack_on_nxt  = 1'b0;
              state_nxt   = RD_ACK;
            end else begin
              sda_oe_nxt   = ~tx_shreg[6];
              tx_shreg_nxt = {tx_shreg[5:0], 1'b0};
              bit_cnt_nxt  = bit_cnt + 3'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise && !ack_on) begin
            if (!sda_f) begin
              tx_req_nxt = 1'b1;
              ack_on_nxt = 1'b1;
            end else begin
              slv_busy_nxt = 1'b0;
              sda_oe_nxt   = 1'b0;
              state_nxt    = WAIT_STOP;
            end
          end else if (scl_fall && ack_on) begin
            ack_on_nxt   = 1'b0;
            tx_shreg_nxt = tx_data[6:0];
            sda_oe_nxt   = ~tx_data[7];
            bit_cnt_nxt  = 3'd0;
            state_nxt    = RD_DATA;
          end
        end
        WAIT_STOP: sda_oe_nxt = 1'b0;
        default: begin
          sda_oe_nxt = 1'b0;
          state_nxt  = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_i2c_slave.sv
// Directed bench for udp_i2c_slave: bit-banged I2C master on a wired-AND SDA line.
module tb_udp_i2c_slave;

  localparam int Q = 20;  // quarter SCL period in clks

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic [6:0] slv_addr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req, start_det, stop_det, slv_busy, slv_rw;

  assign sda_bus = sda_m & ~sda_oe;

  udp_i2c_slave #(.FILT_LEN(3)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe),
    .slv_addr(slv_addr), .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_req(tx_req), .start_det(start_det), .stop_det(stop_det),
    .slv_busy(slv_busy), .slv_rw(slv_rw)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int   rxv_cnt = 0, txr_cnt = 0, sd_cnt = 0, pd_cnt = 0, oe_cnt = 0;
  logic oe_prev = 1'b0;
  always @(negedge clk) begin
    if (rx_valid)  rxv_cnt++;
    if (tx_req)    txr_cnt++;
    if (start_det) sd_cnt++;
    if (stop_det)  pd_cnt++;
    if (sda_oe && !oe_prev) oe_cnt++;
    oe_prev = sda_oe;
  end

  int b_rxv, b_txr, b_sd, b_pd, b_oe;
  task automatic snap();
    b_rxv = rxv_cnt; b_txr = txr_cnt; b_sd = sd_cnt; b_pd = pd_cnt; b_oe = oe_cnt;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic i2c_start(output int lat);
    lat = 0;
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0;
    for (int k = 1; k <= Q; k++) begin
      @(negedge clk);
      if (start_det && lat == 0) lat = k;
    end
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop(output int lat);
    lat = 0;
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1;
    for (int k = 1; k <= Q; k++) begin
      @(negedge clk);
      if (stop_det && lat == 0) lat = k;
    end
    wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q(2);
    scl_m = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    b = sda_bus;  wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(nack);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic       ack;
    logic [7:0] d;

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; slv_addr = 7'h50; tx_data = 8'h00;
    repeat (4) @(negedge clk);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_start_det", start_det, 0);
    chk("rst_stop_det", stop_det, 0);
    chk("rst_busy", slv_busy, 0);
    chk("rst_rw", slv_rw, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Write 0xA5 to address 0x50
    snap();
    i2c_start(lat);       chk("t1_start_lat", lat, 5);
    write_byte(8'hA0, ack); chk("t1_addr_ack", ack, 0);
    chk("t1_busy", slv_busy, 1);
    chk("t1_rw", slv_rw, 0);
    write_byte(8'hA5, ack); chk("t1_data_ack", ack, 0);
    i2c_stop(lat);        chk("t1_stop_lat", lat, 5);
    chk("t1_rx_data", rx_data, 8'hA5);
    chk("t1_rx_valid_cnt", rxv_cnt - b_rxv, 1);
    chk("t1_ack_pulses", oe_cnt - b_oe, 2);
    chk("t1_stop_cnt", pd_cnt - b_pd, 1);
    chk("t1_start_cnt", sd_cnt - b_sd, 1);
    chk("t1_tx_req_cnt", txr_cnt - b_txr, 0);
    chk("t1_busy_end", slv_busy, 0);

    // Single read of 0x3C, NACKed
    tx_data = 8'h3C;
    snap();
    i2c_start(lat);
    write_byte(8'hA1, ack); chk("t2_addr_ack", ack, 0);
    chk("t2_rw", slv_rw, 1);
    chk("t2_tx_req_cnt1", txr_cnt - b_txr, 1);
    read_byte(d, 1'b1);   chk("t2_byte", d, 8'h3C);
    chk("t2_busy_after_nack", slv_busy, 0);
    write_byte(8'h00, ack); chk("t2_wait_stop_noack", ack, 1);
    chk("t2_tx_req_cnt_end", txr_cnt - b_txr, 1);
    i2c_stop(lat);
    chk("t2_sda_oe_idle", sda_oe, 0);

    // Multi-byte read: 0x11 (ACK), 0x22 (ACK), 0x33 (NACK)
    tx_data = 8'h11;
    snap();
    i2c_start(lat);
    write_byte(8'hA1, ack); chk("t3_addr_ack", ack, 0);
    tx_data = 8'h22;
    read_byte(d, 1'b0);   chk("t3_byte0", d, 8'h11);
    tx_data = 8'h33;
    read_byte(d, 1'b0);   chk("t3_byte1", d, 8'h22);
    read_byte(d, 1'b1);   chk("t3_byte2", d, 8'h33);
    chk("t3_tx_req_cnt", txr_cnt - b_txr, 3);
    i2c_stop(lat);

    // Address mismatch: slave stays off the bus
    snap();
    i2c_start(lat);
    write_byte(8'hA2, ack); chk("t4_addr_noack", ack, 1);
    write_byte(8'hFF, ack); chk("t4_data_noack", ack, 1);
    i2c_stop(lat);
    chk("t4_oe_pulses", oe_cnt - b_oe, 0);
    chk("t4_rx_valid_cnt", rxv_cnt - b_rxv, 0);
    chk("t4_busy", slv_busy, 0);

    // Repeated START after 4 data bits, then a read
    tx_data = 8'h5A;
    snap();
    i2c_start(lat);
    write_byte(8'hA0, ack); chk("t5_addr_ack", ack, 0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_start(lat);       chk("t5_rstart_lat", lat, 5);
    write_byte(8'hA1, ack); chk("t5_addr2_ack", ack, 0);
    chk("t5_rw", slv_rw, 1);
    chk("t5_busy", slv_busy, 1);
    read_byte(d, 1'b1);   chk("t5_byte", d, 8'h5A);
    chk("t5_start_cnt", sd_cnt - b_sd, 2);
    chk("t5_rx_valid_cnt", rxv_cnt - b_rxv, 0);
    i2c_stop(lat);

    // Reset while driving a read bit
    tx_data = 8'h00;
    i2c_start(lat);
    write_byte(8'hA1, ack); chk("t6_addr_ack", ack, 0);
    chk("t6_oe_driving", sda_oe, 1);
    rst = 1'b1;
    #1;
    chk("t6_oe_released", sda_oe, 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    snap();
    write_byte(8'hA0, ack); chk("t6_no_start_noack", ack, 1);
    chk("t6_oe_pulses", oe_cnt - b_oe, 0);
    chk("t6_busy", slv_busy, 0);
    i2c_start(lat);
    write_byte(8'hA0, ack); chk("t6_addr_ack2", ack, 0);
    write_byte(8'h77, ack); chk("t6_data_ack", ack, 0);
    i2c_stop(lat);
    chk("t6_rx_data", rx_data, 8'h77);
    chk("t6_rx_valid_cnt", rxv_cnt - b_rxv, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
